serial_parity_engine: RTL and testbench

//  Parametrised serial parity generator/checker for single-bit data streams.

---
 rtl/serial_parity_engine.sv | 150 +++++++++++++++
 tb/tb_serial_parity_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_engine.sv
// -----------------------------------------------------------------------------
// serial_parity_engine
//
// Serial parity generator/checker for single-bit data streams. Collects
// FRAME_BITS data bits per frame (qualified by bit_valid, gaps allowed) and
// reports even or odd parity. In check mode the frame carries one trailing
// received parity bit which is compared against the computed parity.
//
// State table:
//   IDLE | no frame in progress; first accepted bit starts a frame
//   DATA | data bits being accumulated
//   PAR  | all data bits received; waiting for the trailing parity bit
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   bit_in     in   serial data or parity bit
//   bit_valid  in   bit_in accepted on this edge when high
//   odd_mode   in   1 = odd parity, 0 = even; sampled on the first bit of a frame
//   check_en   in   1 = frame carries a trailing parity bit; sampled with odd_mode
//   abort      in   drop the current frame; wins over bit_valid
//   p          out  parity of the last completed frame, held until next p_valid
//   p_valid    out  one-cycle pulse, frame complete
//   err        out  one-cycle pulse with p_valid on check-mode mismatch
//   busy       out  frame partially received
//   bit_count  out  data bits accepted in the current frame
// -----------------------------------------------------------------------------
module serial_parity_engine #(
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             odd_mode,
    input  logic             check_en,
    input  logic             abort,
    output logic             p,
    output logic             p_valid,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

    state_t           state;
    logic             acc;
    logic             mode_q;
    logic             chk_q;

    logic             acc_next;
    logic             mode_eff;
    logic             chk_eff;
    logic [CNT_W-1:0] cnt_next;
    logic             last_bit;
    logic             exp_data;
    logic             exp_par;

    // In IDLE the incoming bit starts a fresh frame, so the accumulator and
    // mode come straight from the inputs rather than from the held registers.
    // This lets the last data bit's parity be produced on the same edge that
    // accepts it.
    always_comb begin
        acc_next = acc ^ bit_in;
        mode_eff = mode_q;
        chk_eff  = chk_q;
        cnt_next = bit_count + CNT_W'(1);
        if (state == IDLE) begin
            acc_next = bit_in;
            mode_eff = odd_mode;
            chk_eff  = check_en;
            cnt_next = CNT_W'(1);
        end
        last_bit = (cnt_next == LAST_CNT);
        exp_data = acc_next ^ mode_eff;
        exp_par  = acc ^ mode_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= 1'b0;
            mode_q    <= 1'b0;
            chk_q     <= 1'b0;
            bit_count <= '0;
            p         <= 1'b0;
            p_valid   <= 1'b0;
            err       <= 1'b0;
        end else begin
            p_valid <= 1'b0;
            err     <= 1'b0;
            if (abort) begin
                // In IDLE these already hold their idle values, so abort is a no-op there.
                state     <= IDLE;
                acc       <= 1'b0;
                bit_count <= '0;
            end else if (bit_valid) begin
                case (state)
                    IDLE, DATA: begin
                        if (state == IDLE) begin
                            mode_q <= odd_mode;
                            chk_q  <= check_en;
                        end
                        if (last_bit) begin
                            if (chk_eff) begin
                                state     <= PAR;
                                acc       <= acc_next;
                                bit_count <= LAST_CNT;
                            end else begin
                                state     <= IDLE;
                                acc       <= 1'b0;
                                bit_count <= '0;
                                p         <= exp_data;
                                p_valid   <= 1'b1;
                            end
                        end else begin
                            state     <= DATA;
                            acc       <= acc_next;
                            bit_count <= cnt_next;
                        end
                    end
                    PAR: begin
                        state     <= IDLE;
                        acc       <= 1'b0;
                        bit_count <= '0;
                        p         <= exp_par;
                        p_valid   <= 1'b1;
                        err       <= (bit_in != exp_par);
                    end
                    default: begin
                        state     <= IDLE;
                        acc       <= 1'b0;
                        bit_count <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_engine.sv
module tb_serial_parity_engine;

    localparam int CW8 = $clog2(9);

    logic           clk = 1'b0;
    logic           reset;
    logic           bit_in, bit_valid, bit_valid1, odd_mode, check_en, abort;
    logic           p, p_valid, err, busy;
    logic [CW8-1:0] bit_count;
    logic           p1, p_valid1, err1, busy1;
    logic [0:0]     bit_count1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit last_p = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_parity_engine #(.FRAME_BITS(8)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .odd_mode(odd_mode), .check_en(check_en), .abort(abort),
        .p(p), .p_valid(p_valid), .err(err), .busy(busy), .bit_count(bit_count)
    );

    serial_parity_engine #(.FRAME_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid1),
        .odd_mode(odd_mode), .check_en(check_en), .abort(abort),
        .p(p1), .p_valid(p_valid1), .err(err1), .busy(busy1), .bit_count(bit_count1)
    );

    // Reference: parity = (number of ones mod 2) xor odd selection.
    function automatic bit model_parity(input logic [7:0] data, input bit odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        return bit'(ones % 2) ^ odd;
    endfunction

    // Sends one frame LSB first to the 8-bit instance, checking progress and result.
    task automatic run_frame(input logic [7:0] data, input bit odd, input bit chk,
                             input bit parbit, input int gap_max, input string name,
                             output int pv_cyc);
        bit exp_p;
        exp_p  = model_parity(data, odd);
        pv_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                bit_valid = 1'b0; bit_in = 1'($urandom);
                odd_mode = 1'($urandom); check_en = 1'($urandom);
                @(posedge clk); #1;
                checks++;
                if (busy !== (i > 0) || bit_count !== CW8'(i) || p_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s gap before bit %0d: busy=%b cnt=%0d pv=%b, expected busy=%b cnt=%0d pv=0",
                             name, i, busy, bit_count, p_valid, (i > 0), i);
                end
            end
            bit_valid = 1'b1; bit_in = data[i];
            odd_mode = (i == 0) ? odd : 1'($urandom);
            check_en = (i == 0) ? chk : 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (i < 7 || chk) begin
                if (busy !== 1'b1 || bit_count !== CW8'(i + 1) || p_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bit %0d: busy=%b cnt=%0d pv=%b, expected busy=1 cnt=%0d pv=0",
                             name, i, busy, bit_count, p_valid, i + 1);
                end
            end else begin
                pv_cyc = cyc;
                if (p_valid !== 1'b1 || p !== exp_p || err !== 1'b0 || busy !== 1'b0 || bit_count !== '0) begin
                    errors++;
                    $display("FAIL %s result: pv=%b p=%b err=%b busy=%b cnt=%0d, expected pv=1 p=%b err=0 busy=0 cnt=0",
                             name, p_valid, p, err, busy, bit_count, exp_p);
                end
            end
        end
        if (chk) begin
            repeat ($urandom_range(gap_max, 0)) begin
                bit_valid = 1'b0; bit_in = 1'($urandom);
                @(posedge clk); #1;
                checks++;
                if (busy !== 1'b1 || bit_count !== CW8'(8) || p_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s parity wait: busy=%b cnt=%0d pv=%b, expected busy=1 cnt=8 pv=0",
                             name, busy, bit_count, p_valid);
                end
            end
            bit_valid = 1'b1; bit_in = parbit;
            odd_mode = 1'($urandom); check_en = 1'($urandom);
            @(posedge clk); #1;
            pv_cyc = cyc;
            checks++;
            if (p_valid !== 1'b1 || p !== exp_p || err !== (parbit != exp_p) || busy !== 1'b0 || bit_count !== '0) begin
                errors++;
                $display("FAIL %s check result: pv=%b p=%b err=%b busy=%b cnt=%0d, expected pv=1 p=%b err=%b busy=0 cnt=0",
                         name, p_valid, p, err, busy, bit_count, exp_p, (parbit != exp_p));
            end
        end
        bit_valid = 1'b0; odd_mode = 1'b0; check_en = 1'b0;
        last_p = exp_p;
    endtask

    task automatic test_reset;
        reset = 1'b1; bit_valid = 1'b1; bit_valid1 = 1'b1; bit_in = 1'b1;
        odd_mode = 1'b1; check_en = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (p !== 1'b0 || p_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || bit_count !== '0 ||
            p1 !== 1'b0 || p_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset: p=%b pv=%b err=%b busy=%b cnt=%0d p1=%b pv1=%b busy1=%b, expected all 0",
                     p, p_valid, err, busy, bit_count, p1, p_valid1, busy1);
        end
        bit_valid = 1'b0; bit_valid1 = 1'b0; odd_mode = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_generate;
        int c;
        run_frame(8'h2D, 1'b0, 1'b0, 1'b0, 0, "gen_even_4ones", c);
        run_frame(8'h2D, 1'b1, 1'b0, 1'b0, 0, "gen_odd_4ones", c);
        run_frame(8'h07, 1'b0, 1'b0, 1'b0, 0, "gen_even_3ones", c);
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (p_valid !== 1'b0 || p !== last_p) begin
                errors++;
                $display("FAIL hold: pv=%b p=%b, expected pv=0 p=%b", p_valid, p, last_p);
            end
        end
    endtask

    task automatic test_check;
        int c;
        run_frame(8'hFF, 1'b0, 1'b1, 1'b1, 0, "check_ff_par1", c);
        run_frame(8'hFF, 1'b0, 1'b1, 1'b0, 0, "check_ff_par0", c);
        run_frame(8'h5A, 1'b1, 1'b1, 1'b0, 2, "check_5a_odd", c);
    endtask

    task automatic test_gaps;
        int c;
        logic [7:0] d;
        d = 8'($urandom);
        run_frame(d, 1'b0, 1'b0, 1'b0, 0, "gapless_ref", c);
        run_frame(d, 1'b0, 1'b0, 1'b0, 4, "gapped", c);
    endtask

    task automatic test_abort_reset;
        int c;
        bit held;
        held = last_p;
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bit_count !== '0 || p_valid !== 1'b0 || p !== held) begin
            errors++;
            $display("FAIL abort_idle: busy=%b cnt=%0d pv=%b p=%b, expected busy=0 cnt=0 pv=0 p=%b",
                     busy, bit_count, p_valid, p, held);
        end
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = 1'($urandom);
            @(posedge clk); #1;
        end
        abort = 1'b1; bit_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bit_count !== '0 || p_valid !== 1'b0 || err !== 1'b0 || p !== held) begin
            errors++;
            $display("FAIL abort_mid: busy=%b cnt=%0d pv=%b err=%b p=%b, expected busy=0 cnt=0 pv=0 err=0 p=%b",
                     busy, bit_count, p_valid, err, p, held);
        end
        abort = 1'b0; bit_valid = 1'b0;
        run_frame(8'h01, 1'b0, 1'b0, 1'b0, 0, "after_abort_01", c);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b1; bit_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (p !== 1'b0 || busy !== 1'b0 || bit_count !== '0 || p_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: p=%b busy=%b cnt=%0d pv=%b, expected all 0", p, busy, bit_count, p_valid);
        end
        last_p = 1'b0;
    endtask

    task automatic test_back_to_back;
        int c0, c1;
        run_frame(8'h03, 1'b0, 1'b0, 1'b0, 0, "b2b_03", c0);
        run_frame(8'h07, 1'b0, 1'b0, 1'b0, 0, "b2b_07", c1);
        checks++;
        if (c1 - c0 !== 8) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, expected 8", c1 - c0);
        end
    endtask

    task automatic test_random;
        int c;
        for (int n = 0; n < 24; n++)
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3, "random", c);
    endtask

    task automatic test_frame1;
        bit b, odd, chk, par, exp_p;
        bit_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            b = 1'($urandom); odd = 1'($urandom); chk = (n < 2) ? 1'b0 : 1'($urandom); par = 1'($urandom);
            exp_p = b ^ odd;
            bit_valid1 = 1'b1; bit_in = b; odd_mode = odd; check_en = chk;
            @(posedge clk); #1;
            checks++;
            if (chk) begin
                if (p_valid1 !== 1'b0 || busy1 !== 1'b1 || bit_count1 !== 1'b1) begin
                    errors++;
                    $display("FAIL fb1_data %0d: pv=%b busy=%b cnt=%0d, expected pv=0 busy=1 cnt=1",
                             n, p_valid1, busy1, bit_count1);
                end
                bit_in = par; odd_mode = ~odd;
                @(posedge clk); #1;
                checks++;
                if (p_valid1 !== 1'b1 || p1 !== exp_p || err1 !== (par != exp_p) || busy1 !== 1'b0) begin
                    errors++;
                    $display("FAIL fb1_check %0d: pv=%b p=%b err=%b busy=%b, expected pv=1 p=%b err=%b busy=0",
                             n, p_valid1, p1, err1, busy1, exp_p, (par != exp_p));
                end
            end else begin
                if (p_valid1 !== 1'b1 || p1 !== exp_p || err1 !== 1'b0 || busy1 !== 1'b0 || bit_count1 !== 1'b0) begin
                    errors++;
                    $display("FAIL fb1_gen %0d: pv=%b p=%b err=%b busy=%b cnt=%0d, expected pv=1 p=%b err=0 busy=0 cnt=0",
                             n, p_valid1, p1, err1, busy1, bit_count1, exp_p);
                end
            end
        end
        bit_valid1 = 1'b0; odd_mode = 1'b0; check_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || p_valid !== 1'b0) begin
            errors++;
            $display("FAIL fb1_isolation: busy=%b pv=%b, expected 0 0", busy, p_valid);
        end
    endtask

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_gaps();
        test_abort_reset();
        test_back_to_back();
        test_random();
        test_frame1();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
